// File: rtl/sample_packer.sv
// sample_packer: decimates probe input, packs reduced-channel samples into FIFO words, flags overrun.
// Ports: clk/rst (sync active-high); enable arms capture; divider/mode latched on IDLE->RUN;
// probe sampled on divider ticks; fifo_full gates the write; sample_data/sample_data_avail drive
// the FIFO write port; overflow is sticky; running marks RUN; word_count counts written words.
module sample_packer #(
  parameter int WIDTH = 16,
  parameter int DIV_WIDTH = 24,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divider,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     probe,
  input  logic                 fifo_full,
  output logic [WIDTH-1:0]     sample_data,
  output logic                 sample_data_avail,
  output logic                 overflow,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] word_count
);
  typedef enum logic [1:0] {IDLE, RUN, OVERRUN} state_t;
  state_t state, state_n;
  logic [DIV_WIDTH-1:0] div_l, div_cnt;
  logic [1:0] mode_l;
  logic [2:0] slot;
  logic [WIDTH-1:0] pack, chans, mask, samp, word;
  logic start, tick, last;
  // New samples enter at the top and shift down, so after a full word the earliest sits lowest.
  always_comb begin
    chans = WIDTH'(WIDTH) >> mode_l;
    mask = ~({WIDTH{1'b1}} << chans);
    samp = probe & mask;
    word = (pack >> chans) | (samp << (WIDTH'(WIDTH) - chans));
    start = state == IDLE && enable;
    tick = state == RUN && enable && div_cnt == '0;
    last = {1'b0, slot} == (4'd1 << mode_l) - 4'd1;
    running = state == RUN;
  end
  always_comb begin
    state_n = state;
    if (start) state_n = RUN;
    else if (tick && last && fifo_full) state_n = OVERRUN;
    else if (state != IDLE && !enable) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_data <= '0;
      sample_data_avail <= 1'b0;
      overflow <= 1'b0;
      word_count <= '0;
      div_l <= '0;
      div_cnt <= '0;
      mode_l <= '0;
      slot <= '0;
      pack <= '0;
    end else begin
      sample_data_avail <= 1'b0;
      if (start) begin
        div_l <= divider;
        mode_l <= mode;
        overflow <= 1'b0;
        word_count <= '0;
        slot <= '0;
        pack <= '0;
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= div_l;
        slot <= last ? 3'd0 : slot + 3'd1;
        pack <= last ? '0 : word;
        if (last) begin
          sample_data <= word;
          if (fifo_full) overflow <= 1'b1;
          else begin
            sample_data_avail <= 1'b1;
            word_count <= word_count + 1'b1;
          end
        end
      end else if (state == RUN && enable) div_cnt <= div_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: directed and random stimulus checked against a behavioural model of sample_packer.
module tb_sample_packer;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, fifo_full = 1'b0;
  logic [23:0] divider = '0;
  logic [1:0] mode = '0;
  logic [15:0] probe = '0;
  logic [15:0] sample_data;
  logic sample_data_avail, overflow, running;
  logic [31:0] word_count;
  int checks = 0, failures = 0, strobes = 0;
  int ms = 0, t = 0, ldiv = 0, lmode = 0;
  int q[$];
  logic [15:0] e_data = '0;
  logic e_avail = 1'b0, e_ovf = 1'b0;
  logic [31:0] e_cnt = '0;

  sample_packer #(.WIDTH(16), .DIV_WIDTH(24), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .enable(enable), .divider(divider), .mode(mode), .probe(probe),
    .fifo_full(fifo_full), .sample_data(sample_data), .sample_data_avail(sample_data_avail),
    .overflow(overflow), .running(running), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // ms: 0 idle, 1 capturing, 2 stopped after a dropped word; t counts capture cycles.
  task automatic model();
    int c, w;
    if (rst) begin
      ms = 0; e_data = '0; e_avail = 1'b0; e_ovf = 1'b0; e_cnt = '0; q.delete();
    end else begin
      e_avail = 1'b0;
      if (ms == 0) begin
        if (enable) begin
          ms = 1; ldiv = int'(divider); lmode = int'(mode);
          e_ovf = 1'b0; e_cnt = '0; t = 0; q.delete();
        end
      end else if (ms == 1) begin
        if (!enable) ms = 0;
        else begin
          if (t % (ldiv + 1) == 0) begin
            c = W >> lmode;
            q.push_back(int'(probe) & ((1 << c) - 1));
            if (q.size() == (1 << lmode)) begin
              w = 0;
              foreach (q[k]) w |= q[k] << (k * c);
              e_data = w[15:0];
              q.delete();
              if (fifo_full) begin e_ovf = 1'b1; ms = 2; end
              else begin e_avail = 1'b1; e_cnt++; end
            end
          end
          t++;
        end
      end else if (!enable) ms = 0;
    end
  endtask

  task automatic step();
    model();
    @(posedge clk);
    @(negedge clk);
    chk("sample_data", 32'(sample_data), 32'(e_data));
    chk("avail", 32'(sample_data_avail), 32'(e_avail));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    chk("running", 32'(running), 32'(ms == 1));
    chk("word_count", word_count, e_cnt);
    if (sample_data_avail) strobes++;
  endtask

  initial begin
    step();
    chk("reset_avail", 32'(sample_data_avail), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    rst = 1'b0; enable = 1'b1;
    step();
    strobes = 0;
    for (int i = 1; i <= 8; i++) begin
      probe = 16'(i);
      step();
      chk("m0_data", 32'(sample_data), i);
    end
    chk("m0_strobes", strobes, 8);
    chk("m0_count", word_count, 8);

    enable = 1'b0; step();
    mode = 2'd1; enable = 1'b1; step();
    strobes = 0;
    probe = 16'h0011; step();
    chk("m1_nostrobe", 32'(sample_data_avail), 0);
    probe = 16'h0022; step();
    chk("m1_word0", 32'(sample_data), 32'h2211);
    chk("m1_avail0", 32'(sample_data_avail), 1);
    probe = 16'h0033; step();
    probe = 16'h0044; step();
    chk("m1_word1", 32'(sample_data), 32'h4433);
    chk("m1_strobes", strobes, 2);

    enable = 1'b0; step();
    mode = 2'd3; divider = 24'd3; probe = 16'h0001; enable = 1'b1; step();
    strobes = 0;
    for (int i = 0; i < 64; i++) step();
    chk("m3_strobes", strobes, 2);
    chk("m3_data", 32'(sample_data), 32'h5555);

    enable = 1'b0; step();
    mode = 2'd0; divider = 24'd0; enable = 1'b1; step();
    strobes = 0;
    for (int i = 0; i < 4; i++) begin probe = 16'($urandom); step(); end
    fifo_full = 1'b1; step();
    fifo_full = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("ovr_flag", 32'(overflow), 1);
    chk("ovr_running", 32'(running), 0);
    chk("ovr_count", word_count, 4);
    chk("ovr_strobes", strobes, 4);
    enable = 1'b0; step();
    chk("ovr_sticky_idle", 32'(overflow), 1);
    enable = 1'b1; step();
    chk("rearm_flag", 32'(overflow), 0);
    chk("rearm_count", word_count, 0);
    probe = 16'hBEEF; step();
    chk("rearm_data", 32'(sample_data), 32'hBEEF);

    enable = 1'b0; step();
    mode = 2'd2; enable = 1'b1; step();
    strobes = 0;
    for (int i = 0; i < 3; i++) begin probe = 16'h000F; step(); end
    enable = 1'b0; step();
    chk("drop_strobes", strobes, 0);
    chk("drop_running", 32'(running), 0);
    enable = 1'b1; step();
    for (int i = 1; i <= 4; i++) begin probe = 16'(i); step(); end
    chk("drop_fresh", 32'(sample_data), 32'h4321);

    enable = 1'b0; step();
    mode = 2'd1; enable = 1'b1; step();
    probe = 16'h00AB; step();
    rst = 1'b1; step();
    chk("rst_data", 32'(sample_data), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_count", word_count, 0);
    rst = 1'b0; step();
    chk("rst_rerun", 32'(running), 1);

    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(199) == 0);
      enable = ($urandom_range(49) != 0);
      fifo_full = ($urandom_range(15) == 0);
      probe = 16'($urandom);
      if ($urandom_range(30) == 0) begin
        mode = 2'($urandom);
        divider = 24'($urandom_range(5));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Parametrised sampling front end for the logic analyser capture path.
- Sits between the probe inputs and the capture FIFO write port (sample_data/sample_data_avail), running on the fast sampling clock.
- Decimates the input by a programmable divider and packs 1, 2, 4 or 8 samples of a reduced channel set into one FIFO word.
- Detects FIFO overrun, stops, and flags it sticky.

Parameters:
- WIDTH, 16, probe width and FIFO word width; must be a multiple of 8.
- DIV_WIDTH, 24, width of the sample-rate divider.
- CNT_WIDTH, 32, width of the emitted-word counter.

Ports:
- clk  input  1  sampling clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture enable; level-sensitive.
- divider  input  DIV_WIDTH  sample period minus 1, in clk cycles.
- mode  input  2  channel mode: channels = WIDTH>>mode; samples per word = 1<<mode.
- probe  input  WIDTH  probe inputs, already synchronised to clk.
- fifo_full  input  1  FIFO full flag, clk domain.
- sample_data  output  WIDTH  packed word to FIFO.
- sample_data_avail  output  1  one-cycle write strobe for sample_data.
- overflow  output  1  sticky overrun flag.
- running  output  1  high in RUN state.
- word_count  output  CNT_WIDTH  words successfully written since capture start.

Behaviour:
- Reset values: sample_data=0, sample_data_avail=0, overflow=0, running=0, word_count=0, state=IDLE.
- Reset also clears the pack shift register, slot counter and divider counter.
- States:
  - IDLE -> RUN when enable=1. On entry: latch divider and mode, clear overflow, word_count, slot counter and pack register; load divider counter with 0.
  - RUN -> IDLE when enable=0. A partial word is discarded and no strobe is issued.
  - RUN -> OVERRUN on a dropped word (see below).
  - OVERRUN -> IDLE when enable=0.
- running=1 only in RUN.
- Divider counter, RUN only:
  - Tick when the counter is 0, then reload it with the latched divider; otherwise decrement.
  - divider=0 gives a tick every cycle; divider=N gives a tick every N+1 cycles.
  - The first tick occurs in the first RUN cycle.
- On each tick:
  - Capture probe[C-1:0], where C = WIDTH>>mode.
  - Sample k (k = 0..(1<<mode)-1) of the current word occupies bits [k*C +: C]; the earliest sample lands in the lowest bits.
  - The slot counter increments and wraps at 1<<mode.
- Word complete on the tick that fills the last slot:
  - Next cycle: sample_data holds the word.
  - If fifo_full was 0 on the completing tick cycle: sample_data_avail=1 for exactly one cycle and word_count increments (wraps modulo 2^CNT_WIDTH).
  - If fifo_full was 1: no strobe, overflow<=1, state -> OVERRUN. No further ticks or strobes until re-armed.
- sample_data holds its last value between strobes; the strobe is never high for more than one consecutive cycle unless both divider=0 and mode=0.
- Changing divider or mode while in RUN has no effect until the next IDLE->RUN.
- overflow remains set through IDLE and clears only on reset or the next IDLE->RUN.
- rst asserted mid-capture: all outputs return to reset values on the following edge. No strobe is issued in that cycle.

Test Plan:
- WIDTH=16, mode=0, divider=0, probe incrementing from 0x0001 each cycle, enable held -> strobe every cycle; data 0x0001, 0x0002, ... one cycle after capture; word_count=8 after 8 strobes.
- mode=1, divider=0, probe low byte 0x11, 0x22, 0x33, 0x44 on successive cycles -> two strobes with data 0x2211 then 0x4433; each strobe is one cycle after its second sample.
- mode=3 (2 channels), divider=3, probe[1:0]=2'b01 constantly -> one strobe every 32 cycles with data 0x5555.
- mode=0, divider=0; fifo_full=1 on the 5th completing tick -> 4 strobes then no more; overflow=1, running=0, word_count=4. Drop enable and re-raise -> overflow=0, word_count=0, capture resumes.
- mode=2, divider=0; enable drops after 3 of 4 samples -> no strobe, running=0. Re-enable -> the next word contains only new samples.
- rst pulsed mid-RUN with mode=1 and one sample pending -> next cycle all outputs 0, state IDLE; with enable still high, RUN is re-entered the following cycle.
